// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared funct3 codes, FSM states and lane helpers for the data-side LSU
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, ACCESS} state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating store data across lanes lets the controller pick bytes by mask alone
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts and sign/zero-extends a 32-bit read word into a load result
module lsu_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_dataout,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load_data
);

    logic [31:0] w_sh;

    assign w_sh = i_dataout >> {i_addr_lo, 3'b000};

    always_comb begin
        o_load_data = i_dataout;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_BU:   o_load_data = {24'b0, w_sh[7:0]};
            F3_H:    o_load_data = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_HU:   o_load_data = {16'b0, w_sh[15:0]};
            default: o_load_data = i_dataout;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with alignment checks and access watchdog
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] address,
    output logic [31:0] datain,
    output logic        wen,
    output logic        ren,
    output logic [3:0]  byte_select_vector,
    input  logic        memReady,
    input  logic [31:0] dataout,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned_exc,
    output logic        illegal_exc,
    output logic        timeout_exc
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t        r_state, w_next;
    logic [CW-1:0] r_wait_cnt;
    logic [2:0]    r_funct3;
    logic [31:0]   r_address, r_datain, r_load_data;
    logic [3:0]    r_bsv;
    logic          r_ren, r_wen, r_done, r_mis, r_ill, r_to;
    logic          w_resp, w_go, w_f3_ok, w_illegal, w_misal;
    logic          w_accept, w_complete, w_timeout;
    logic [31:0]   w_aligned;

    assign w_resp    = r_done | r_mis | r_ill | r_to;
    assign w_go      = (r_state == IDLE) && req_valid && !w_resp && (mem_read || mem_write);
    assign w_f3_ok   = mem_write ? (funct3 inside {F3_B, F3_H, F3_W})
                                 : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_illegal = (mem_read && mem_write) || !w_f3_ok;
    assign w_misal   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go && !w_illegal && !w_misal) begin
                    w_accept = 1'b1;
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                // A ready on the watchdog's final cycle still completes the access
                if (memReady) begin
                    w_complete = 1'b1;
                    w_next     = IDLE;
                end else if ((TIMEOUT != 0) && (r_wait_cnt == LAST)) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    lsu_load_align u_align (
        .i_dataout   (dataout),
        .i_addr_lo   (r_address[1:0]),
        .i_funct3    (r_funct3),
        .o_load_data (w_aligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_funct3    <= 3'b0;
            r_address   <= 32'b0;
            r_datain    <= 32'b0;
            r_load_data <= 32'b0;
            r_bsv       <= 4'b0;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_done      <= 1'b0;
            r_mis       <= 1'b0;
            r_ill       <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            r_done <= w_complete;
            r_to   <= w_timeout;
            r_ill  <= w_go && w_illegal;
            r_mis  <= w_go && !w_illegal && w_misal;
            if (w_accept) begin
                r_address  <= addr;
                r_datain   <= lane_data(funct3, store_data);
                r_bsv      <= lane_mask(funct3, addr[1:0]);
                r_ren      <= mem_read;
                r_wen      <= mem_write;
                r_funct3   <= funct3;
                r_wait_cnt <= '0;
            end else if (w_complete || w_timeout) begin
                r_ren <= 1'b0;
                r_wen <= 1'b0;
            end else if (r_state == ACCESS) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_complete && r_ren) r_load_data <= w_aligned;
        end
    end

    assign address            = r_address;
    assign datain             = r_datain;
    assign byte_select_vector = r_bsv;
    assign ren                = r_ren;
    assign wen                = r_wen;
    assign done               = r_done;
    assign misaligned_exc     = r_mis;
    assign illegal_exc        = r_ill;
    assign timeout_exc        = r_to;
    assign load_data          = r_load_data;
    assign stall              = reset && req_valid && !w_resp;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - vector table plus hand sequences for mem_access_unit
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset, req_valid, mem_read, mem_write, memReady;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, dataout;
    logic [31:0] address, datain, load_data;
    logic        wen, ren, stall, done, misaligned_exc, illegal_exc, timeout_exc;
    logic [3:0]  byte_select_vector;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .address(address), .datain(datain), .wen(wen), .ren(ren),
        .byte_select_vector(byte_select_vector), .memReady(memReady), .dataout(dataout),
        .stall(stall), .done(done), .load_data(load_data), .misaligned_exc(misaligned_exc),
        .illegal_exc(illegal_exc), .timeout_exc(timeout_exc)
    );

    // kind: 0 done, 1 misaligned, 2 illegal, 3 timeout
    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, sd, dout;
        int          delay;
        int          kind;
        logic [3:0]  bsv;
        logic [31:0] din, ld;
    } vec_t;

    typedef struct {
        int          kind;
        int          n_act;
        logic [31:0] ld;
    } exp_t;

    vec_t        vt[16];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_ld = 32'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int resp_kind();
        if (done)           return 0;
        if (misaligned_exc) return 1;
        if (illegal_exc)    return 2;
        if (timeout_exc)    return 3;
        return 7;
    endfunction

    task automatic pop_check(input int n_act);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("resp_kind", 32'(resp_kind()), 32'(e.kind));
        chk("active_cycles", 32'(n_act), 32'(e.n_act));
        chk("load_data", load_data, e.ld);
    endtask

    function automatic vec_t mk(input logic rd, wr, input logic [2:0] f3,
                                input logic [31:0] a, sd, dout, input int delay, kind,
                                input logic [3:0] bsv, input logic [31:0] din, ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd; v.dout = dout;
        v.delay = delay; v.kind = kind; v.bsv = bsv; v.din = din; v.ld = ld;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
        addr = v.a; store_data = v.sd; dataout = v.dout; memReady = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n_act = 0;
        bit   got = 0;
        drive(v);
        e.kind  = v.kind;
        e.n_act = (v.kind == 0) ? v.delay + 1 : (v.kind == 3 ? TO : 0);
        if (v.kind == 0 && v.rd) m_ld = v.ld;
        e.ld = m_ld;
        sb.push_back(e);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ren || wen) begin
                n_act++;
                if (n_act == 1 || !memReady) begin
                    chk("ren", 32'(ren), 32'(v.rd));
                    chk("wen", 32'(wen), 32'(v.wr));
                    chk("address", address, v.a);
                    chk("bsv", 32'(byte_select_vector), 32'(v.bsv));
                    chk("datain", datain, v.din);
                end
                memReady = (n_act > v.delay);
            end
            if (resp_kind() != 7) begin
                got = 1;
                chk("stall_resp", 32'(stall), 32'd0);
                chk("ren_wen_resp", 32'({ren, wen}), 32'd0);
                pop_check(n_act);
            end else begin
                chk("stall_busy", 32'(stall), 32'd1);
            end
        end
        if (!got) chk("resp_wait_expired", 32'd0, 32'd1);
        req_valid = 1'b0; memReady = 1'b0;
        @(negedge clk);
        chk("pulse_width", 32'({done, misaligned_exc, illegal_exc, timeout_exc}), 32'd0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        addr = 32'b0; store_data = 32'b0; dataout = 32'b0; memReady = 1'b1;

        vt[0]  = mk(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
        vt[1]  = mk(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
        vt[2]  = mk(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 0, 0, 4'b1000, 32'h0, 32'h00000080);
        vt[3]  = mk(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 0, 4'b1100, 32'hABCDABCD, 32'h0);
        vt[4]  = mk(1, 0, 3'b010, 32'h101, 0, 32'h0, 0, 1, 4'b0, 32'h0, 32'h0);
        vt[5]  = mk(1, 0, 3'b011, 32'h100, 0, 32'h0, 0, 2, 4'b0, 32'h0, 32'h0);
        vt[6]  = mk(1, 0, 3'b001, 32'h102, 0, 32'h80011234, 0, 0, 4'b1100, 32'h0, 32'hFFFF8001);
        vt[7]  = mk(1, 0, 3'b101, 32'h100, 0, 32'h1234F00D, 2, 0, 4'b0011, 32'h0, 32'h0000F00D);
        vt[8]  = mk(0, 1, 3'b000, 32'h001, 32'h000000A5, 32'h0, 1, 0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        vt[9]  = mk(0, 1, 3'b010, 32'h004, 32'h12345678, 32'h0, 0, 0, 4'b1111, 32'h12345678, 32'h0);
        vt[10] = mk(0, 1, 3'b001, 32'h001, 32'h1, 32'h0, 0, 1, 4'b0, 32'h0, 32'h0);
        vt[11] = mk(1, 1, 3'b010, 32'h100, 32'h1, 32'h0, 0, 2, 4'b0, 32'h0, 32'h0);
        vt[12] = mk(0, 1, 3'b100, 32'h100, 32'h1, 32'h0, 0, 2, 4'b0, 32'h0, 32'h0);
        vt[13] = mk(1, 0, 3'b010, 32'h108, 0, 32'h0, 100, 3, 4'b1111, 32'h0, 32'h0);
        vt[14] = mk(1, 0, 3'b010, 32'h10C, 0, 32'hCAFEF00D, TO - 1, 0, 4'b1111, 32'h0, 32'hCAFEF00D);
        vt[15] = mk(1, 0, 3'b000, 32'h101, 0, 32'h00007F00, 0, 0, 4'b0010, 32'h0, 32'h0000007F);

        @(negedge clk);
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vt[i]);

        // Back-to-back: the second request must wait out one bubble after done
        drive(mk(1, 0, 3'b010, 32'h100, 0, 32'h11111111, 0, 0, 4'b1111, 0, 0));
        memReady = 1'b1;
        m_ld = 32'h11111111;
        sb.push_back('{0, 1, 32'h11111111});
        @(negedge clk); chk("b2b_ren1", 32'(ren), 32'd1);
        @(negedge clk); pop_check(1);
        drive(mk(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 0, 0, 4'b1000, 0, 0));
        memReady = 1'b1;
        @(negedge clk);
        chk("b2b_bubble_ren", 32'(ren), 32'd0);
        chk("b2b_bubble_stall", 32'(stall), 32'd1);
        @(negedge clk); chk("b2b_ren2", 32'(ren), 32'd1);
        m_ld = 32'h00000080;
        sb.push_back('{0, 1, 32'h00000080});
        @(negedge clk); pop_check(1);
        req_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an access
        drive(mk(1, 0, 3'b010, 32'h100, 0, 32'h0, 0, 0, 4'b1111, 0, 0));
        @(negedge clk); chk("mid_ren", 32'(ren), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_ren", 32'(ren), 32'd0);
        chk("arst_address", address, 32'd0);
        chk("arst_bsv", 32'(byte_select_vector), 32'd0);
        chk("arst_load_data", load_data, 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; memReady = 1'b1;
        #1 chk("post_rst_stall0", 32'(stall), 32'd0);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        #1 chk("post_rst_stall1", 32'(stall), 32'd1);
        repeat (3) @(negedge clk);
        chk("noop_ren", 32'({ren, wen}), 32'd0);
        chk("noop_stall", 32'(stall), 32'd1);
        chk("noop_done", 32'(done), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side initiator for the data-memory controller: takes a load/store request from the MEM stage and drives address, datain, wen/ren and byte_select_vector to the controller.
- Waits on memReady, captures and sign/zero-extends load data, and holds the pipeline stall until the access completes.
- Detects misaligned and illegal accesses without touching memory, and aborts hung accesses through a watchdog.

Parameters:
- TIMEOUT, 0: maximum ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage request; held stable until done/exception.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address.
- store_data  in  32  store operand, right-aligned.
- address  out  32  byte address to controller; controller does the >>2.
- datain  out  32  lane-replicated store data.
- wen  out  1  write enable to controller.
- ren  out  1  read enable to controller.
- byte_select_vector  out  4  active byte lanes.
- memReady  in  1  controller ready; 1 = access completes this cycle.
- dataout  in  32  controller read data.
- stall  out  1  pipeline hold.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result.
- misaligned_exc  out  1  one-cycle pulse.
- illegal_exc  out  1  one-cycle pulse.
- timeout_exc  out  1  one-cycle pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including load_data, address and byte_select_vector.
  - wen/ren drop immediately; any in-flight access is abandoned.
- Decode:
  - Valid codes are LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use SB 000, SH 001, SW 010.
  - Any other code, or mem_read&&mem_write, is illegal.
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
- Response cycle: resp = done | any exc pulse.
- stall = req_valid && !resp.
- IDLE: at a posedge with req_valid && !resp && (mem_read||mem_write):
  - Illegal: illegal_exc=1 next cycle; stay IDLE.
  - Else misaligned: misaligned_exc=1 next cycle; stay IDLE.
  - Else: register address=addr and the request; go ACCESS.
  - Lane and data encoding:
    - byte_select_vector: 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word.
    - datain: {4{sd[7:0]}} for byte, {2{sd[15:0]}} for half, sd for word.
  - req_valid with neither read nor write: no action, stall=1 indefinitely. This is a pipeline error; the bench flags it.
- ACCESS:
  - ren or wen held at 1, with address/datain/byte_select_vector stable every cycle.
  - wait_cnt increments each cycle.
  - At a posedge with memReady=1:
    - Load: load_data <= extract(dataout, addr[1:0], funct3). Store: load_data unchanged.
    - done=1 next cycle; ren/wen=0; go IDLE.
  - At a posedge with memReady=0 and TIMEOUT!=0 and wait_cnt==TIMEOUT-1: timeout_exc=1 next cycle; ren/wen=0; go IDLE.
  - memReady wins over timeout on the same edge.
- Load extraction:
  - sh = dataout >> (8*addr[1:0]).
  - LB = sext(sh[7:0]), LBU = zext(sh[7:0]), LH = sext(sh[15:0]), LHU = zext(sh[15:0]), LW = dataout.
- Latency: minimum 2 cycles from accept edge to done (ACCESS 1 cycle, then done cycle). Each extra memReady=0 cycle adds 1.
- Pulse timing: done and exc pulses last exactly one cycle; load_data stays valid until the next load completes.
- Back-to-back requests: a new request is never accepted during a resp cycle, so there is exactly one bubble between requests.
- Signals with no effect:
  - memReady while IDLE is ignored; the controller reports 1 during its own reset.
  - Changes to req_valid/addr during ACCESS do not affect the registered request.
- wait_cnt width: $clog2(TIMEOUT+1), minimum 1; cleared on entering ACCESS.

Decomposition:
- Package mem_access_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, ACCESS}, lane-mask function.
- Sub-module lsu_load_align: combinational dataout/addr[1:0]/funct3 -> load_data extraction, reusable by the instruction-side fetch path.

Test Plan:
- Reset: drive reset=0 mid-ACCESS with ren=1 -> ren=0 in the same cycle; all outputs 0; after release, state IDLE and stall follows req_valid.
- LW 0x100, memReady=1, dataout=0xDEADBEEF:
  - Accept edge -> ren=1, address=0x100, bsv=1111 for one cycle.
  - Next cycle: done=1, load_data=0xDEADBEEF.
  - stall=1 until the done cycle.
- LB 0x103, dataout=0x80123456 -> bsv=1000, load_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH 0x202, store_data=0x0000ABCD, memReady=0 for 3 ACCESS cycles then 1:
  - wen=1 for 4 cycles, datain=0xABCDABCD, bsv=1100.
  - done one cycle after memReady rises; load_data unchanged.
- LW 0x101 -> misaligned_exc pulse, ren/wen never asserted, stall=0 in pulse cycle. funct3=011 load -> illegal_exc pulse.
- TIMEOUT=8, memReady stuck 0 -> ren high exactly 8 cycles, then timeout_exc pulse, ren=0. Repeat with memReady=1 on the 8th cycle -> done, no timeout.
